// File: rtl/weight_ram_loader_if.sv
// Loader bus: host-side load control, weight write handshake, row read port and status.
interface weight_ram_loader_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned NCH   = 10,
    parameter int unsigned DEPTH = 128
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                 load_start;
    logic [AW-1:0]        load_addr;
    logic [AW:0]          load_rows;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WIDTH-1:0]     wr_data;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [NCH*WIDTH-1:0] rd_q;
    logic                 rd_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output load_start, load_addr, load_rows, wr_valid, wr_data, rd_en, rd_addr,
        input  wr_ready, rd_q, rd_valid, busy, done
    );

    modport slave (
        input  load_start, load_addr, load_rows, wr_valid, wr_data, rd_en, rd_addr,
        output wr_ready, rd_q, rd_valid, busy, done
    );
endinterface

// File: rtl/weight_ram_loader.sv
// Packs NCH streamed weights per row into NCH channel banks with a registered row read port.
// Optional WEIGHT_LFSR_INIT_EN adds rand_start_i and an LFSR-driven bank fill state.
module weight_ram_loader #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned NCH       = 10,
    parameter int unsigned DEPTH     = 128,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef WEIGHT_LFSR_INIT_EN
    input  logic rand_start_i,
`endif
    weight_ram_loader_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = AW + 1;
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef WEIGHT_LFSR_INIT_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_COMMIT, S_DONE, S_RAND} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT, S_DONE} state_e;
`endif

    state_e                    state_q, state_d;
    logic                      wr_ready_q, wr_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [CW-1:0]             chan_cnt_q;
    logic [AW-1:0]             row_addr_q;
    logic [RW-1:0]             row_cnt_q;
    logic [RW-1:0]             rows_tgt_q;
    logic [NCH-1:0][WIDTH-1:0] stage_q;
    logic [NCH-1:0][WIDTH-1:0] rd_q_q;
    logic [NCH-1:0][WIDTH-1:0] bank_rd;
    logic                      rd_valid_q;

    logic          xfer;
    logic          last_chan;
    logic          rows_left;
    logic [RW-1:0] rows_sat;
    logic [AW-1:0] row_addr_nxt;

    assign xfer         = bus.wr_valid && wr_ready_q;
    assign last_chan    = (chan_cnt_q == CW'(NCH - 1));
    assign rows_left    = ((row_cnt_q + RW'(1)) < rows_tgt_q);
    assign rows_sat     = (bus.load_rows > RW'(DEPTH)) ? RW'(DEPTH) : bus.load_rows;
    assign row_addr_nxt = (row_addr_q == AW'(DEPTH - 1)) ? '0 : row_addr_q + AW'(1);

`ifdef WEIGHT_LFSR_INIT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    logic        rand_last;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign rand_last = last_chan && (row_cnt_q == RW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                lfsr_q <= LFSR_SEED;
        else if (state_q == S_RAND) lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
`endif

    // State and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    state_d = (rows_sat == '0) ? S_DONE : S_COLLECT;
                end
`ifdef WEIGHT_LFSR_INIT_EN
                else if (rand_start_i) begin
                    state_d = S_RAND;
                end
`endif
            end
            S_COLLECT: if (xfer && last_chan) state_d = S_COMMIT;
            S_COMMIT:  state_d = rows_left ? S_COLLECT : S_DONE;
            S_DONE:    state_d = S_IDLE;
`ifdef WEIGHT_LFSR_INIT_EN
            S_RAND:    if (rand_last) state_d = S_DONE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with state_q.
    always_comb begin
        wr_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        wr_ready_d = (state_d == S_COLLECT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_cnt_q <= '0;
            row_addr_q <= '0;
            row_cnt_q  <= '0;
            rows_tgt_q <= '0;
            stage_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load_start) begin
                        row_addr_q <= bus.load_addr;
                        rows_tgt_q <= rows_sat;
                        row_cnt_q  <= '0;
                        chan_cnt_q <= '0;
                    end
`ifdef WEIGHT_LFSR_INIT_EN
                    else if (rand_start_i) begin
                        row_addr_q <= '0;
                        row_cnt_q  <= '0;
                        chan_cnt_q <= '0;
                    end
`endif
                end
                S_COLLECT: begin
                    if (xfer) begin
                        stage_q[chan_cnt_q] <= bus.wr_data;
                        chan_cnt_q          <= last_chan ? '0 : chan_cnt_q + CW'(1);
                    end
                end
                S_COMMIT: begin
                    row_addr_q <= row_addr_nxt;
                    row_cnt_q  <= row_cnt_q + RW'(1);
                end
`ifdef WEIGHT_LFSR_INIT_EN
                S_RAND: begin
                    chan_cnt_q <= last_chan ? '0 : chan_cnt_q + CW'(1);
                    if (last_chan) begin
                        row_addr_q <= row_addr_nxt;
                        row_cnt_q  <= row_cnt_q + RW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // One bank per channel; RAND writes a single channel per cycle, COMMIT writes all.
    for (genvar c = 0; c < NCH; c++) begin : g_bank
        logic [WIDTH-1:0] mem [DEPTH];
        logic             we;
        logic [WIDTH-1:0] wd;

`ifdef WEIGHT_LFSR_INIT_EN
        assign we = (state_q == S_COMMIT) ||
                    ((state_q == S_RAND) && (chan_cnt_q == CW'(c)));
        assign wd = (state_q == S_RAND) ? WIDTH'(lfsr_q) : stage_q[c];
`else
        assign we = (state_q == S_COMMIT);
        assign wd = stage_q[c];
`endif

        always_ff @(posedge clk) begin
            if (we) mem[row_addr_q] <= wd;
        end

        assign bank_rd[c] = mem[bus.rd_addr];
    end

    // Read register samples pre-write contents, so a same-row COMMIT returns the old row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_q_q <= bank_rd;
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_q     = rd_q_q;
endmodule
